// File: rtl/data_sram_arb_pkg.sv
// Shared definitions for the data SRAM arbiter: port identifiers and the
// packed request bundle layout {wen, addr, wdata} used by both requesters.
package data_sram_arb_pkg;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  // Width of one packed request bundle {wen[DW/8], addr[AW], wdata[DW]}.
  function automatic int unsigned req_bundle_w(input int unsigned aw, input int unsigned dw);
    return (dw / 8) + aw + dw;
  endfunction

endpackage

// File: rtl/data_sram_arb_rr_arb2.sv
// Two-input round-robin grant logic with an anti-starvation cap that bounds
// how many times B may win in a row while A is waiting.
module rr_arb2
  import data_sram_arb_pkg::*;
#(
  parameter int unsigned B_HOLD_MAX = 4,
  localparam int unsigned CW = $clog2(B_HOLD_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  localparam logic [CW-1:0] CAP = CW'(B_HOLD_MAX);

  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] b_cnt_q, b_cnt_d;

  always_comb begin
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    if (rst) begin
      if (a_req_i && b_req_i) begin
        // Contention: the cap overrides round-robin in A's favour.
        if ((b_cnt_q == CAP) || (last_gnt_q == OWN_B)) begin
          a_gnt_o = 1'b1;
        end else begin
          b_gnt_o = 1'b1;
        end
      end else begin
        a_gnt_o = a_req_i;
        b_gnt_o = b_req_i;
      end
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (a_gnt_o) begin
      last_gnt_d = OWN_A;
    end else if (b_gnt_o) begin
      last_gnt_d = OWN_B;
    end

    b_cnt_d = b_cnt_q;
    if (!a_req_i || a_gnt_o) begin
      b_cnt_d = '0;
    end else if (b_gnt_o && (b_cnt_q != CAP)) begin
      b_cnt_d = b_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt_q <= OWN_B;
      b_cnt_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      b_cnt_q    <= b_cnt_d;
    end
  end

endmodule

// File: rtl/data_sram_arb.sv
// Data SRAM port arbiter between the CPU MEM stage (A) and a debug/DMA
// master (B): same-cycle grant, one-cycle read return routed to the owner.
module data_sram_arb
  import data_sram_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned B_HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_req,
  input  logic [DW/8-1:0] a_wen,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  output logic            a_gnt,
  output logic            a_rvalid,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_req,
  input  logic [DW/8-1:0] b_wen,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  output logic            b_gnt,
  output logic            b_rvalid,
  output logic [DW-1:0]   b_rdata,
  output logic            sram_en,
  output logic [DW/8-1:0] sram_wen,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata,
  output logic            stall_req
);

  // Handshake: a requester raises req with stable fields and holds them until
  // gnt is seen high in the same cycle; that cycle is the transfer. Reads
  // answer with rvalid exactly one cycle later; there is no back-pressure.

  localparam int unsigned REQ_W = req_bundle_w(AW, DW);

  logic [REQ_W-1:0] a_bundle, b_bundle, g_bundle;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_own_q, rd_own_d;

  rr_arb2 #(
    .B_HOLD_MAX(B_HOLD_MAX)
  ) u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .a_req_i(a_req),
    .b_req_i(b_req),
    .a_gnt_o(a_gnt),
    .b_gnt_o(b_gnt)
  );

  assign a_bundle = {a_wen, a_addr, a_wdata};
  assign b_bundle = {b_wen, b_addr, b_wdata};

  always_comb begin
    g_bundle = '0;
    if (a_gnt) begin
      g_bundle = a_bundle;
    end else if (b_gnt) begin
      g_bundle = b_bundle;
    end
  end

  assign sram_en = a_gnt | b_gnt;
  assign {sram_wen, sram_addr, sram_wdata} = g_bundle;

  always_comb begin
    rd_vld_d = sram_en && (sram_wen == '0);
    rd_own_d = rd_own_q;
    if (rd_vld_d) begin
      rd_own_d = b_gnt ? OWN_B : OWN_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_vld_q <= 1'b0;
      rd_own_q <= OWN_A;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_own_q <= rd_own_d;
    end
  end

  assign a_rvalid  = rst & rd_vld_q & (rd_own_q == OWN_A);
  assign b_rvalid  = rst & rd_vld_q & (rd_own_q == OWN_B);
  assign a_rdata   = a_rvalid ? sram_rdata : '0;
  assign b_rdata   = b_rvalid ? sram_rdata : '0;
  assign stall_req = rst & a_req & ~a_gnt;

endmodule

// File: tb/tb_data_sram_arb.sv
// Bench for data_sram_arb: directed scenarios plus a randomized run checked
// against a rule-level model of grants, SRAM drive and read returns.
module tb_data_sram_arb;
  import data_sram_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int HOLD = 2;
  localparam int VW   = 3 + BW + AW + DW + 1 + DW + 1 + DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_req, b_req;
  logic [BW-1:0] a_wen, b_wen;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          sram_en;
  logic [BW-1:0] sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic          stall_req;

  data_sram_arb #(.AW(AW), .DW(DW), .B_HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .stall_req(stall_req)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who won last, B's run length, and pending read tags {vld, own}.
  logic       m_last = OWN_B;
  int         m_bcnt = 0;
  logic [1:0] exp_q[$];

  logic          exp_a_gnt, exp_b_gnt, exp_sram_en, exp_a_rvalid, exp_b_rvalid, exp_stall;
  logic [BW-1:0] exp_sram_wen;
  logic [AW-1:0] exp_sram_addr;
  logic [DW-1:0] exp_sram_wdata, exp_a_rdata, exp_b_rdata;

  function automatic void model_eval();
    logic [1:0] tag;
    logic       a_win;
    tag = exp_q[0];
    {exp_a_gnt, exp_b_gnt, exp_sram_en, exp_a_rvalid, exp_b_rvalid, exp_stall} = '0;
    exp_sram_wen = '0; exp_sram_addr = '0; exp_sram_wdata = '0;
    if (rst) begin
      if (a_req && b_req) a_win = (m_bcnt >= HOLD) || (m_last == OWN_B);
      else a_win = a_req;
      exp_a_gnt = a_win;
      exp_b_gnt = b_req && !a_win;
      exp_sram_en = exp_a_gnt || exp_b_gnt;
      if (exp_a_gnt) {exp_sram_wen, exp_sram_addr, exp_sram_wdata} = {a_wen, a_addr, a_wdata};
      else if (exp_b_gnt) {exp_sram_wen, exp_sram_addr, exp_sram_wdata} = {b_wen, b_addr, b_wdata};
      exp_a_rvalid = tag[1] && (tag[0] == OWN_A);
      exp_b_rvalid = tag[1] && (tag[0] == OWN_B);
      exp_stall = a_req && !exp_a_gnt;
    end
    exp_a_rdata = exp_a_rvalid ? sram_rdata : '0;
    exp_b_rdata = exp_b_rvalid ? sram_rdata : '0;
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    logic [1:0] tag;
    @(posedge clk);
    tag = 2'b00;
    if (!rst) begin
      m_last = OWN_B;
      m_bcnt = 0;
    end else begin
      if (exp_sram_en) begin
        tag = {(exp_sram_wen == '0), exp_b_gnt};
        m_last = exp_b_gnt ? OWN_B : OWN_A;
      end
      if (!a_req || exp_a_gnt) m_bcnt = 0;
      else if (exp_b_gnt && m_bcnt < HOLD) m_bcnt = m_bcnt + 1;
    end
    void'(exp_q.pop_front());
    exp_q.push_back(tag);
  endtask

  task automatic idle_inputs();
    a_req = 0; a_wen = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wen = '0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 0;
      a_req = 1'($urandom_range(0, 1)); b_req = 1'($urandom_range(0, 1));
      a_addr = $urandom; sram_rdata = $urandom;
      settle();
      total++;
      if ({a_gnt, b_gnt, sram_en, a_rvalid, b_rvalid, stall_req} !== 6'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=000000", i,
                 {a_gnt, b_gnt, sram_en, a_rvalid, b_rvalid, stall_req});
      end
      tick();
    end
    @(negedge clk);
    rst = 1; idle_inputs();
    settle();
    total++;
    if ({a_gnt, b_gnt, sram_en, a_rvalid, b_rvalid, stall_req, sram_addr} !== '0) begin
      bad++;
      $display("FAIL reset_release got gnt=%b%b en=%b rv=%b%b stall=%b addr=%h want all 0",
               a_gnt, b_gnt, sram_en, a_rvalid, b_rvalid, stall_req, sram_addr);
    end
    tick();
  endtask

  task automatic test_single_read();
    @(negedge clk);
    idle_inputs();
    a_req = 1; a_addr = 32'h100;
    settle();
    total++;
    if ({a_gnt, b_gnt, sram_en, stall_req, sram_wen, sram_addr} !== {4'b1010, 4'b0, 32'h100}) begin
      bad++;
      $display("FAIL single_read_grant got gnt=%b%b en=%b stall=%b wen=%b addr=%h want 1,0,1,0,0000,100",
               a_gnt, b_gnt, sram_en, stall_req, sram_wen, sram_addr);
    end
    tick();
    @(negedge clk);
    idle_inputs();
    sram_rdata = 32'hDEADBEEF;
    settle();
    total++;
    if ({a_rvalid, b_rvalid, stall_req, a_rdata, b_rdata} !== {3'b100, 32'hDEADBEEF, 32'h0}) begin
      bad++;
      $display("FAIL single_read_data got rv=%b%b stall=%b a_rdata=%h b_rdata=%h want 1,0,0,deadbeef,0",
               a_rvalid, b_rvalid, stall_req, a_rdata, b_rdata);
    end
    tick();
  endtask

  task automatic test_alternate();
    logic exp_a;
    @(negedge clk);
    rst = 0; idle_inputs();
    settle();
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1;
      a_req = 1; a_addr = 32'(i * 8);
      b_req = 1; b_addr = 32'(i * 8 + 4);
      sram_rdata = $urandom;
      settle();
      exp_a = (i % 2 == 0);
      total++;
      if ({a_gnt, b_gnt, stall_req} !== {exp_a, !exp_a, !exp_a}) begin
        bad++;
        $display("FAIL alternate cyc=%0d got a_gnt=%b b_gnt=%b stall=%b want %b %b %b",
                 i, a_gnt, b_gnt, stall_req, exp_a, !exp_a, !exp_a);
      end
      tick();
    end
  endtask

  task automatic test_b_write();
    @(negedge clk);
    idle_inputs();
    b_req = 1; b_wen = 4'b0011; b_addr = 32'h20; b_wdata = 32'h12345678;
    settle();
    total++;
    if ({b_gnt, sram_en, sram_wen, sram_addr, sram_wdata} !== {2'b11, 4'b0011, 32'h20, 32'h12345678}) begin
      bad++;
      $display("FAIL b_write_drive got gnt=%b en=%b wen=%b addr=%h wdata=%h want 1,1,0011,20,12345678",
               b_gnt, sram_en, sram_wen, sram_addr, sram_wdata);
    end
    tick();
    @(negedge clk);
    idle_inputs();
    sram_rdata = 32'hCAFEF00D;
    settle();
    total++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0) begin
      bad++;
      $display("FAIL b_write_no_resp got rv=%b%b a_rdata=%h b_rdata=%h want 0,0,0,0",
               a_rvalid, b_rvalid, a_rdata, b_rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    int deny_run;
    @(negedge clk);
    idle_inputs(); a_req = 1; settle(); tick();
    @(negedge clk);
    idle_inputs(); settle(); tick();
    @(negedge clk);
    a_req = 1; b_req = 1; b_addr = 32'h40;
    settle();
    total++;
    if ({a_gnt, b_gnt, stall_req} !== 3'b011) begin
      bad++;
      $display("FAIL starve_b_first got a_gnt=%b b_gnt=%b stall=%b want 0 1 1", a_gnt, b_gnt, stall_req);
    end
    tick();
    deny_run = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(a_req && !a_gnt)) a_req = 1'($urandom_range(0, 3) != 0);
      b_req = 1;
      b_addr = $urandom;
      settle();
      total++;
      if (a_gnt !== exp_a_gnt) begin
        bad++;
        $display("FAIL starve_model cyc=%0d got a_gnt=%b want %b", i, a_gnt, exp_a_gnt);
      end
      deny_run = (a_req && !a_gnt) ? deny_run + 1 : 0;
      total++;
      if (deny_run > HOLD) begin
        bad++;
        $display("FAIL starve_cap cyc=%0d got deny_run=%0d want <=%0d", i, deny_run, HOLD);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle_inputs(); a_req = 1; a_addr = 32'h0;
    settle();
    total++;
    if (a_gnt !== 1'b1) begin
      bad++;
      $display("FAIL b2b_grant_a got %b want 1", a_gnt);
    end
    tick();
    @(negedge clk);
    idle_inputs(); b_req = 1; b_addr = 32'h4; sram_rdata = 32'h11;
    settle();
    total++;
    if ({b_gnt, a_rvalid, b_rvalid, a_rdata} !== {3'b110, 32'h11}) begin
      bad++;
      $display("FAIL b2b_cycle1 got b_gnt=%b rv=%b%b a_rdata=%h want 1,1,0,11",
               b_gnt, a_rvalid, b_rvalid, a_rdata);
    end
    tick();
    @(negedge clk);
    idle_inputs(); sram_rdata = 32'h22;
    settle();
    total++;
    if ({a_rvalid, b_rvalid, b_rdata, a_rdata} !== {2'b01, 32'h22, 32'h0}) begin
      bad++;
      $display("FAIL b2b_cycle2 got rv=%b%b b_rdata=%h a_rdata=%h want 0,1,22,0",
               a_rvalid, b_rvalid, b_rdata, a_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    idle_inputs(); a_req = 1; a_addr = 32'h80;
    settle();
    total++;
    if (a_gnt !== 1'b1) begin
      bad++;
      $display("FAIL midrst_grant got %b want 1", a_gnt);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = (i == 1); idle_inputs(); sram_rdata = $urandom;
      settle();
      total++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
        bad++;
        $display("FAIL midrst_no_rvalid cyc=%0d got rv=%b%b want 00", i, a_rvalid, b_rvalid);
      end
      tick();
    end
    @(negedge clk);
    a_req = 1; b_req = 1;
    settle();
    total++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL midrst_a_first got a_gnt=%b b_gnt=%b want 1 0", a_gnt, b_gnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [VW-1:0] obs, exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) != 0);
      if (!(a_req && !a_gnt && rst)) begin
        a_req = 1'($urandom_range(0, 1));
        a_wen = ($urandom_range(0, 1) != 0) ? '0 : BW'($urandom);
        a_addr = $urandom; a_wdata = $urandom;
      end
      if (!(b_req && !b_gnt && rst)) begin
        b_req = 1'($urandom_range(0, 1));
        b_wen = ($urandom_range(0, 1) != 0) ? '0 : BW'($urandom);
        b_addr = $urandom; b_wdata = $urandom;
      end
      sram_rdata = $urandom;
      settle();
      obs = {a_gnt, b_gnt, sram_en, sram_wen, sram_addr, sram_wdata,
             a_rvalid, a_rdata, b_rvalid, b_rdata, stall_req};
      exp = {exp_a_gnt, exp_b_gnt, exp_sram_en, exp_sram_wen, exp_sram_addr, exp_sram_wdata,
             exp_a_rvalid, exp_a_rdata, exp_b_rvalid, exp_b_rdata, exp_stall};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp);
      end
      tick();
    end
    @(negedge clk);
    rst = 1; idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    sram_rdata = '0;
    exp_q.push_back(2'b00);
    test_reset();
    test_single_read();
    test_alternate();
    test_b_write();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
